word_scan_sequencer: RTL
========================

// Module: word_scan_sequencer
// PURPOSE
//  Upstream/downstream companion of the generated 12:4 mux tree. Holds a 12-entry x 4-bit word bank,
//  presents it flat on mux_a, sweeps mux_s 0..11 on start and streams each mux result out on a
//  valid/ready port. Connects a host write port to a downstream consumer through the combinational mux.
// PARAMETERS
//  N_WORDS  12  words in bank; sweep covers indices 0..N_WORDS-1
//  WIDTH    4   bits per word (= mux output width)
//  SEL_W    4   select/index width; 2**SEL_W >= N_WORDS
// PORTS
//  clk        in   1               system clock, rising edge
//  rst_n      in   1               asynchronous, active-low reset
//  wr_ena     in   1               bank write strobe
//  wr_addr    in   SEL_W           bank write index
//  wr_data    in   WIDTH           bank write data
//  start      in   1               begin one sweep (sampled in IDLE only)
//  busy       out  1               high in SCAN/HOLD
//  done       out  1               one-cycle pulse after the last index is consumed
//  mux_a      out  N_WORDS*WIDTH   bank contents to mux; word i at [WIDTH*i+WIDTH-1 : WIDTH*i]
//  mux_s      out  SEL_W           mux select (registered index)
//  mux_y      in   WIDTH           mux result (combinational from mux_a/mux_s)
//  out_valid  out  1               out_data/out_index valid
//  out_ready  in   1               consumer accepts beat when out_valid & out_ready
//  out_data   out  WIDTH           captured mux_y
//  out_index  out  SEL_W           index that produced out_data
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, bank all 0, mux_s=0, out_valid=0, out_data=0, out_index=0,
//    busy=0, done=0. Reset mid-sweep aborts immediately; no done pulse.
//  - Bank: on clk with wr_ena & ~busy & (wr_addr < N_WORDS), bank[wr_addr] <= wr_data. Writes while busy
//    or to wr_addr >= N_WORDS are dropped. mux_a is a direct register view.
//  - FSM: IDLE -> SCAN on start (mux_s <= 0). start while busy is ignored.
//    SCAN: one cycle; mux_s stable, so mux_y is settled. At edge: out_data <= mux_y, out_index <= mux_s,
//      out_valid <= 1, -> HOLD.
//    HOLD: out_valid, out_data, out_index held stable until out_ready. On out_valid & out_ready:
//      out_valid <= 0; if mux_s == N_WORDS-1 -> DONE, else mux_s <= mux_s+1, -> SCAN.
//    DONE: done=1 for exactly one cycle, mux_s <= 0, -> IDLE.
//  - Throughput: 2 cycles/beat with out_ready tied high; N_WORDS beats per sweep, 2*N_WORDS+1 cycles
//    start-to-done. First out_valid 2 cycles after start sampled.
//  - mux_s never exceeds N_WORDS-1 (padding entries 12..15 of the mux are never selected).
//  - A write in the same cycle as start: write completes (busy still 0), start is taken; the sweep
//    sees the new value.
// CONFIGURATION
//  WORD_SCAN_SKIP_ZERO_EN defined: in SCAN, if mux_y == 0 no beat is emitted; index advances directly
//   (or -> DONE if last). All-zero bank gives done with zero beats, N_WORDS+1 cycles start-to-done.
//  Undefined: every index emits a beat, including zero words.
// STRUCTURE
//  - word_scan_pkg: state enum {S_IDLE, S_SCAN, S_HOLD, S_DONE}, default N_WORDS/WIDTH/SEL_W constants.
//  - Sub-module word_bank (register file + flat mux_a packing, write-enable gating).
//  - The mux itself is instantiated by the parent, not inside this block.
// TESTING (bench instantiates mux12_4 between mux_a/mux_s and mux_y)
//  - Reset: rst_n=0 mid-HOLD -> out_valid=0, busy=0, mux_s=0, bank zeroed, no done pulse.
//  - Load bank[i]=i+1 (i=0..11), start, out_ready=1 -> 12 beats (index i, data i+1), done at cycle 25.
//  - Backpressure: out_ready low 5 cycles on beat 3 -> out_data=4, out_index=3 held stable, then resumes.
//  - Writes while busy to addr 2 and to wr_addr=13 at idle -> both dropped; re-sweep shows bank unchanged.
//  - Start during sweep -> ignored; exactly one done pulse; start+write same cycle -> new value streamed.
//  - SKIP_ZERO_EN: bank={0,5,0,...,0,9 at 11} -> beats (1,5),(11,9) only; all-zero -> done, no beats.

Source files
------------

// File: rtl/word_scan_pkg.sv
// ----------------------------------------------------------------------------
// word_scan_pkg
// Shared constants and types for the word scan sequencer slice.
//   N_WORDS : number of words in the bank (sweep covers 0..N_WORDS-1)
//   WIDTH   : bits per word, equal to the external mux output width
//   SEL_W   : select/index width, 2**SEL_W >= N_WORDS
//   state_t : sequencer FSM states
// ----------------------------------------------------------------------------
package word_scan_pkg;

    localparam int N_WORDS = 12;
    localparam int WIDTH   = 4;
    localparam int SEL_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_HOLD,
        S_DONE
    } state_t;

endpackage

// File: rtl/word_scan_sequencer_if.sv
// ----------------------------------------------------------------------------
// word_scan_sequencer_if
// Bundles the host write port, the sweep control, the link to the external
// 12:4 mux and the valid/ready output stream of word_scan_sequencer.
//   slave  : view used by word_scan_sequencer
//   master : view used by whatever drives the host side, the mux result and
//            the downstream consumer
// ----------------------------------------------------------------------------
interface word_scan_sequencer_if;
    import word_scan_pkg::*;

    logic                     wr_ena;
    logic [SEL_W-1:0]         wr_addr;
    logic [WIDTH-1:0]         wr_data;
    logic                     start;
    logic                     busy;
    logic                     done;
    logic [N_WORDS*WIDTH-1:0] mux_a;
    logic [SEL_W-1:0]         mux_s;
    logic [WIDTH-1:0]         mux_y;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
    logic [SEL_W-1:0]         out_index;

    modport slave (
        input  wr_ena, wr_addr, wr_data, start, mux_y, out_ready,
        output busy, done, mux_a, mux_s, out_valid, out_data, out_index
    );

    modport master (
        output wr_ena, wr_addr, wr_data, start, mux_y, out_ready,
        input  busy, done, mux_a, mux_s, out_valid, out_data, out_index
    );

endinterface

// File: rtl/word_bank.sv
// ----------------------------------------------------------------------------
// word_bank
// N_WORDS x WIDTH register file exposed as one flat vector for the mux.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears all words)
//   wr_ena     : write strobe
//   wr_addr    : word index; indices >= N_WORDS are ignored
//   wr_data    : word to store
//   lock       : high while a sweep runs; blocks all writes
//   mux_a      : word i at [WIDTH*i +: WIDTH], straight from the registers
// ----------------------------------------------------------------------------
module word_bank
    import word_scan_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_ena,
    input  logic [SEL_W-1:0]         wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     lock,
    output logic [N_WORDS*WIDTH-1:0] mux_a
);

    logic [WIDTH-1:0] bank_q [N_WORDS];
    logic             wr_accept;

    // The address range check keeps the padding mux slots unwritable.
    assign wr_accept = wr_ena & ~lock & (wr_addr < SEL_W'(N_WORDS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_WORDS; i++) begin
                bank_q[i] <= '0;
            end
        end else if (wr_accept) begin
            bank_q[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < N_WORDS; g++) begin : g_pack
        assign mux_a[WIDTH*g +: WIDTH] = bank_q[g];
    end

endmodule

// File: rtl/word_scan_sequencer.sv
// ----------------------------------------------------------------------------
// word_scan_sequencer
// Holds a word bank, presents it flat to an external 12:4 mux, sweeps the
// mux select over 0..N_WORDS-1 on start and streams every mux result out on
// a valid/ready port.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, aborts a sweep without a done pulse
//   bus   : word_scan_sequencer_if.slave (write port, start/busy/done,
//           mux_a/mux_s/mux_y, out_valid/out_ready/out_data/out_index)
// Configuration:
//   WORD_SCAN_SKIP_ZERO_EN : when defined, indices whose word reads zero
//                            advance without emitting a beat.
// ----------------------------------------------------------------------------
module word_scan_sequencer
    import word_scan_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    word_scan_sequencer_if.slave bus
);

    state_t                   state_q;
    state_t                   state_d;
    logic [SEL_W-1:0]         mux_s_q;
    logic                     out_valid_q;
    logic [WIDTH-1:0]         out_data_q;
    logic [SEL_W-1:0]         out_index_q;
    logic                     busy;
    logic                     done;
    logic                     last_index;
    logic                     skip_word;
    logic [N_WORDS*WIDTH-1:0] mux_a_w;

    word_bank u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_ena  (bus.wr_ena),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .lock    (busy),
        .mux_a   (mux_a_w)
    );

    assign last_index = (mux_s_q == SEL_W'(N_WORDS - 1));

`ifdef WORD_SCAN_SKIP_ZERO_EN
    assign skip_word = (bus.mux_y == '0);
`else
    assign skip_word = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (bus.start) state_d = S_SCAN;
            S_SCAN: begin
                if (!skip_word) begin
                    state_d = S_HOLD;
                end else if (last_index) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SCAN;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    state_d = last_index ? S_DONE : S_SCAN;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_SCAN) || (state_q == S_HOLD);
        done = (state_q == S_DONE);
    end

    // The mux is combinational off registered mux_a/mux_s, so mux_y has
    // settled by the end of the single SCAN cycle and can be captured there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_s_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) mux_s_q <= '0;
                end
                S_SCAN: begin
                    if (skip_word) begin
                        if (!last_index) mux_s_q <= mux_s_q + 1'b1;
                    end else begin
                        out_data_q  <= bus.mux_y;
                        out_index_q <= mux_s_q;
                        out_valid_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (!last_index) mux_s_q <= mux_s_q + 1'b1;
                    end
                end
                S_DONE: mux_s_q <= '0;
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.mux_a     = mux_a_w;
    assign bus.mux_s     = mux_s_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_index = out_index_q;

endmodule
